i2s_receive: RTL
================

Name: i2s_receive

Overview:
- Deserialises a Philips-format I2S serial stream (external sck/ws/sd) into stereo sample words.
- Presents the words on an AXI4-Stream master as left (TLAST=0) then right (TLAST=1), the word order the i2s_transmit stage consumes.
- Sits upstream of the transmit/visualiser path; all logic runs in the AXIS clock domain.
- sck, ws and sd are oversampled; M_AXIS_ACLK must be at least 4x the sck frequency.

Parameters:
- DATA_WIDTH, 32, width of each sample word and of M_AXIS_TDATA.
- FIFO_DEPTH, 4, output FIFO entries; power of two, minimum 2.

Ports:
- M_AXIS_ACLK  input  1  system clock.
- M_AXIS_ARESET  input  1  synchronous, active-high reset.
- sck  input  1  I2S bit clock, asynchronous.
- ws  input  1  I2S word select (0 = left, 1 = right), asynchronous.
- sd  input  1  I2S serial data, MSB first, asynchronous.
- M_AXIS_TDATA  output  DATA_WIDTH  sample word.
- M_AXIS_TLAST  output  1  0 = left word, 1 = right word.
- M_AXIS_TVALID  output  1  word available.
- M_AXIS_TREADY  input  1  downstream accept.
- overrun  output  1  sticky flag: at least one frame dropped.

Behaviour:
- Sync:
  - sck passes through a 3-flop chain; sck_rise = chain[2:1] == 2'b01.
  - ws and sd pass through 2-flop chains, so they are aligned with chain[1].
- On each sck_rise (all other cycles hold state):
  - ws_prev <= ws_s.
  - If bitcnt < DATA_WIDTH: shift <= {shift[DATA_WIDTH-2:0], sd_s} and bitcnt increments (saturates at DATA_WIDTH).
- Word boundary:
  - Condition: sck_rise with ws_s != ws_prev. Per I2S timing, the sd bit sampled on this edge is the LSB of the previous word.
  - Completed word = shift including this bit, left-justified: if bitcnt+1 < DATA_WIDTH, the missing LSBs are zero. Bits beyond DATA_WIDTH are ignored.
  - Channel = ws_prev.
  - Afterwards bitcnt <= 0 and shift <= 0.
- Startup: a `synced` flag clears on reset and sets at the first word boundary. The word completed at that first boundary is discarded.
- Pair-preserving push (at a boundary, once synced):
  - Left word: pushed only if FIFO free entries >= 2, and left_ok <= 1. Otherwise dropped, left_ok <= 0, overrun <= 1.
  - Right word: pushed if left_ok == 1; free space is guaranteed by the left check. Otherwise dropped silently.
  - A right word arriving first after sync is dropped (left_ok resets to 0).
  - Net rule: the stream never contains an unpaired word, and TLAST strictly alternates 0,1,0,1.
- FIFO:
  - Entries are {channel, word}, with a registered write.
  - TVALID = not empty. TDATA/TLAST come from the head entry and are stable while TVALID && !TREADY.
  - Pop when TVALID && TREADY. A simultaneous push and pop in the same cycle is allowed; occupancy is unchanged.
  - Latency: boundary sck_rise cycle -> entry written at the next clock edge -> TVALID high the following cycle when the FIFO was empty.
- Reset (any time, including mid-word or mid-frame):
  - TVALID=0, overrun=0, FIFO emptied, synced=0, left_ok=0, bitcnt=0, shift=0, ws_prev=0, sync chains=0.
  - Reset does not wait for TREADY; the in-flight word is lost.
- overrun clears only on reset.

Decomposition:
- Shared package i2s_pkg:
  - CH_LEFT=1'b0, CH_RIGHT=1'b1.
  - SYNC_STAGES=2.
  - Function clog2 for the FIFO pointer width.
- Sub-module axis_sync_fifo (parameters WIDTH=DATA_WIDTH+1, DEPTH=FIFO_DEPTH):
  - Ports: clk, rst, wr_en, wr_data, rd_en, rd_data, empty, free_count.
  - Reusable for a later upstream FIFO in front of i2s_transmit.
- Top level holds the sync, shift/boundary logic and push policy.

Test Plan:
- Normal stream (ACLK 100 MHz, sck 3.072 MHz, 32-bit frames):
  - Stimulus: left 0xA5A5_0001, right 0x5A5A_0002, repeated, TREADY=1.
  - Response: first full pair emitted as TDATA 0xA5A5_0001/TLAST=0 then 0x5A5A_0002/TLAST=1; overrun=0.
- Startup alignment:
  - Stimulus: reset released while ws=1 mid-right-word.
  - Response: partial word and first right word dropped; first output beat has TLAST=0.
- Backpressure:
  - Stimulus: TREADY=0 for 3 frames, then 1.
  - Response: exactly 2 pairs (FIFO_DEPTH=4) emitted, in order; overrun=1; TLAST still alternates.
- Short word:
  - Stimulus: 24 sck per channel, left bits 0xABCDEF.
  - Response: TDATA=0xABCD_EF00.
- Handshake hold:
  - Stimulus: toggle TREADY pseudo-randomly.
  - Response: TDATA/TLAST never change while TVALID && !TREADY; no beat lost or duplicated over 100 frames.
- Mid-frame reset:
  - Stimulus: assert M_AXIS_ARESET for 2 cycles during bit 10 of a right word with 1 entry queued.
  - Response: TVALID=0 next cycle, overrun=0; output resumes with a left word after the next full left channel.

Source files
------------

// File: rtl/i2s_pkg.sv
// Shared definitions for the I2S receive path: channel encoding, synchroniser depth
// and a constant log2 helper used for pointer and counter widths.
package i2s_pkg;

   typedef enum logic {
      CH_LEFT  = 1'b0,
      CH_RIGHT = 1'b1
   } channel_e;

   localparam int unsigned SYNC_STAGES = 2;

   // Ceiling log2; returns 0 for values of 0 or 1.
   function automatic int unsigned clog2(input int unsigned value);
      int unsigned r;
      r = 0;
      while ((64'd1 << r) < 64'(value)) begin
         r = r + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/axis_sync_fifo.sv
// Single-clock FIFO with registered write and first-word-fall-through read port.
// DEPTH must be a power of two so the pointers wrap naturally.
module axis_sync_fifo import i2s_pkg::*; #(
   parameter int unsigned WIDTH = 33,
   parameter int unsigned DEPTH = 4,
   localparam int unsigned AW = clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             empty,
   output logic [AW:0]      free_count
);

   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic             do_wr, do_rd;

   always_comb begin
      do_rd = rd_en && (count_q != '0);
      // A write into a full FIFO is still accepted when a read frees the slot this cycle.
      do_wr = wr_en && ((count_q != FULL_CNT) || do_rd);

      mem_d = mem_q;
      if (do_wr) begin
         mem_d[wr_ptr_q] = wr_data;
      end

      wr_ptr_d = wr_ptr_q;
      if (do_wr) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end

      rd_ptr_d = rd_ptr_q;
      if (do_rd) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end

      count_d = count_q;
      case ({do_wr, do_rd})
         2'b10:   count_d = count_q + (AW+1)'(1);
         2'b01:   count_d = count_q - (AW+1)'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign rd_data    = mem_q[rd_ptr_q];
   assign empty      = (count_q == '0);
   assign free_count = FULL_CNT - count_q;

endmodule

// File: rtl/i2s_receive.sv
// Philips I2S deserialiser: oversamples sck/ws/sd, assembles left/right words and
// queues them as strictly paired AXI4-Stream beats (left TLAST=0, right TLAST=1).
module i2s_receive import i2s_pkg::*; #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                  M_AXIS_ACLK,
   input  logic                  M_AXIS_ARESET,
   input  logic                  sck,
   input  logic                  ws,
   input  logic                  sd,
   output logic [DATA_WIDTH-1:0] M_AXIS_TDATA,
   output logic                  M_AXIS_TLAST,
   output logic                  M_AXIS_TVALID,
   input  logic                  M_AXIS_TREADY,
   output logic                  overrun
);

   localparam int unsigned CW = clog2(DATA_WIDTH + 1);
   localparam int unsigned FW = clog2(FIFO_DEPTH) + 1;
   localparam logic [CW-1:0] FULL_BITS = CW'(DATA_WIDTH);

   logic [2:0]             sck_sync_q, sck_sync_d;
   logic [SYNC_STAGES-1:0] ws_sync_q, ws_sync_d;
   logic [SYNC_STAGES-1:0] sd_sync_q, sd_sync_d;
   logic                   ws_prev_q, ws_prev_d;
   logic [DATA_WIDTH-1:0]  shift_q, shift_d;
   logic [CW-1:0]          bitcnt_q, bitcnt_d;
   logic                   synced_q, synced_d;
   logic                   left_ok_q, left_ok_d;
   logic                   overrun_q, overrun_d;

   logic                   sck_rise, ws_s, sd_s, boundary;
   logic [DATA_WIDTH-1:0]  word;
   logic                   push, pop, fifo_empty;
   logic [DATA_WIDTH:0]    wr_data, rd_data;
   logic [FW-1:0]          free_count;

   assign sck_rise = (sck_sync_q[2:1] == 2'b01);
   assign ws_s     = ws_sync_q[SYNC_STAGES-1];
   assign sd_s     = sd_sync_q[SYNC_STAGES-1];
   assign boundary = sck_rise && (ws_s != ws_prev_q);

   // The bit sampled on the boundary edge is the LSB of the finishing word; short
   // words are left-justified, bits past DATA_WIDTH were never shifted in.
   always_comb begin
      if (bitcnt_q < FULL_BITS) begin
         word = {shift_q[DATA_WIDTH-2:0], sd_s} << (FULL_BITS - bitcnt_q - CW'(1));
      end else begin
         word = shift_q;
      end
   end

   always_comb begin
      sck_sync_d = {sck_sync_q[1:0], sck};
      ws_sync_d  = {ws_sync_q[SYNC_STAGES-2:0], ws};
      sd_sync_d  = {sd_sync_q[SYNC_STAGES-2:0], sd};
      ws_prev_d  = ws_prev_q;
      shift_d    = shift_q;
      bitcnt_d   = bitcnt_q;
      synced_d   = synced_q;
      left_ok_d  = left_ok_q;
      overrun_d  = overrun_q;
      push       = 1'b0;

      if (sck_rise) begin
         ws_prev_d = ws_s;
         if (boundary) begin
            shift_d  = '0;
            bitcnt_d = '0;
            synced_d = 1'b1;
            // A right word only follows an accepted left word, so its slot is reserved.
            if (synced_q) begin
               if (ws_prev_q == CH_LEFT) begin
                  if (free_count >= FW'(2)) begin
                     push      = 1'b1;
                     left_ok_d = 1'b1;
                  end else begin
                     left_ok_d = 1'b0;
                     overrun_d = 1'b1;
                  end
               end else if (left_ok_q) begin
                  push = 1'b1;
               end
            end
         end else if (bitcnt_q < FULL_BITS) begin
            shift_d  = {shift_q[DATA_WIDTH-2:0], sd_s};
            bitcnt_d = bitcnt_q + CW'(1);
         end
      end
   end

   always_ff @(posedge M_AXIS_ACLK) begin
      if (M_AXIS_ARESET) begin
         sck_sync_q <= '0;
         ws_sync_q  <= '0;
         sd_sync_q  <= '0;
         ws_prev_q  <= 1'b0;
         shift_q    <= '0;
         bitcnt_q   <= '0;
         synced_q   <= 1'b0;
         left_ok_q  <= 1'b0;
         overrun_q  <= 1'b0;
      end else begin
         sck_sync_q <= sck_sync_d;
         ws_sync_q  <= ws_sync_d;
         sd_sync_q  <= sd_sync_d;
         ws_prev_q  <= ws_prev_d;
         shift_q    <= shift_d;
         bitcnt_q   <= bitcnt_d;
         synced_q   <= synced_d;
         left_ok_q  <= left_ok_d;
         overrun_q  <= overrun_d;
      end
   end

   assign wr_data = {ws_prev_q, word};
   assign pop     = M_AXIS_TVALID && M_AXIS_TREADY;

   axis_sync_fifo #(
      .WIDTH (DATA_WIDTH + 1),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk        (M_AXIS_ACLK),
      .rst        (M_AXIS_ARESET),
      .wr_en      (push),
      .wr_data    (wr_data),
      .rd_en      (pop),
      .rd_data    (rd_data),
      .empty      (fifo_empty),
      .free_count (free_count)
   );

   assign M_AXIS_TVALID = !fifo_empty;
   assign M_AXIS_TDATA  = rd_data[DATA_WIDTH-1:0];
   assign M_AXIS_TLAST  = rd_data[DATA_WIDTH];
   assign overrun       = overrun_q;

endmodule
